// File: rtl/fp_addsub_ctrl.sv
// Operand screening and sequencing stage in front of a registered single-precision add/sub core.
// Special operand pairs are answered directly. All other pairs go through the core, and exponent overflow saturates to infinity.
module fp_addsub_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic        in_op,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic        core_as,
  input  logic [31:0] core_o,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [3:0]  out_flags
);

  localparam int unsigned W  = 32;
  localparam int unsigned EW = 8;
  localparam int unsigned MW = 23;
  localparam int unsigned FW = 4;

  localparam logic [W-1:0]  QNAN     = 32'h7FC0_0000;
  localparam logic [FW-1:0] F_NAN_BP = 4'b1001;
  localparam logic [FW-1:0] F_INF_BP = 4'b0101;
  localparam logic [FW-1:0] F_ZER_BP = 4'b0011;
  localparam logic [FW-1:0] F_BP     = 4'b0001;
  localparam logic [FW-1:0] F_INF    = 4'b0100;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_OUT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  core_a_q, core_a_d, core_b_q, core_b_d;
  logic          core_as_q, core_as_d;
  logic [W-1:0]  result_q, result_d;
  logic [FW-1:0] flags_q, flags_d;
  logic          in_ready_q, in_ready_d, out_valid_q, out_valid_d;

  logic [EW-1:0] exp_a, exp_b;
  logic          sb_eff, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic          byp_hit;
  logic [W-1:0]  byp_res;
  logic [FW-1:0] byp_flags;

  // Classify the incoming pair with B's sign folded with the op; denormals count as zero
  always_comb begin
    exp_a     = in_a[W-2 -: EW];
    exp_b     = in_b[W-2 -: EW];
    sb_eff    = in_b[W-1] ^ in_op;
    a_zero    = (exp_a == '0);
    b_zero    = (exp_b == '0);
    a_inf     = (exp_a == '1) && (in_a[MW-1:0] == '0);
    b_inf     = (exp_b == '1) && (in_b[MW-1:0] == '0);
    a_nan     = (exp_a == '1) && (in_a[MW-1:0] != '0);
    b_nan     = (exp_b == '1) && (in_b[MW-1:0] != '0);
    byp_hit   = 1'b1;
    byp_res   = '0;
    byp_flags = '0;
    if (a_nan || b_nan) begin
      byp_res   = QNAN;
      byp_flags = F_NAN_BP;
    end else if (a_inf && b_inf && (in_a[W-1] != sb_eff)) begin
      byp_res   = QNAN;
      byp_flags = F_NAN_BP;
    end else if (a_inf) begin
      byp_res   = in_a;
      byp_flags = F_INF_BP;
    end else if (b_inf) begin
      byp_res   = {sb_eff, in_b[W-2:0]};
      byp_flags = F_INF_BP;
    end else if (a_zero && b_zero) begin
      byp_res   = {in_a[W-1] & sb_eff, (W-1)'(0)};
      byp_flags = F_ZER_BP;
    end else if (a_zero) begin
      byp_res   = {sb_eff, in_b[W-2:0]};
      byp_flags = F_BP;
    end else if (b_zero) begin
      byp_res   = in_a;
      byp_flags = F_BP;
    end else if ((in_a[W-2:0] == in_b[W-2:0]) && (in_a[W-1] != sb_eff)) begin
      byp_res   = '0;
      byp_flags = F_ZER_BP;
    end else begin
      byp_hit   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      core_a_q    <= '0;
      core_b_q    <= '0;
      core_as_q   <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      core_a_q    <= core_a_d;
      core_b_q    <= core_b_d;
      core_as_q   <= core_as_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    core_a_d  = core_a_q;
    core_b_d  = core_b_q;
    core_as_d = core_as_q;
    result_d  = result_q;
    flags_d   = flags_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          core_a_d  = in_a;
          core_b_d  = in_b;
          core_as_d = in_op;
          if (byp_hit) begin
            result_d = byp_res;
            flags_d  = byp_flags;
            state_d  = S_OUT;
          end else begin
            state_d  = S_EXEC;
          end
        end
      end
      S_EXEC: state_d = S_CAPT;
      S_CAPT: begin
        // Any all-ones exponent coming back from the core is an overflow; force a clean infinity
        if (core_o[W-2 -: EW] == '1) begin
          result_d = {core_o[W-1], {EW{1'b1}}, MW'(0)};
          flags_d  = F_INF;
        end else begin
          result_d = core_o;
          flags_d  = '0;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign core_a     = core_a_q;
  assign core_b     = core_b_q;
  assign core_as    = core_as_q;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// Directed bench for fp_addsub_ctrl with a table-driven stub standing in for the registered add/sub core.
module tb_fp_addsub_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_op, core_as, out_valid, out_ready;
  logic [31:0] in_a, in_b, core_a, core_b, core_o, out_result;
  logic [3:0]  out_flags;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fp_addsub_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .core_a(core_a), .core_b(core_b), .core_as(core_as), .core_o(core_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  // Core stub knows only the non-special pairs used below; overflow answers have junk mantissas
  function automatic logic [31:0] core_model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] r;
    r = 32'h1234_5678;
    if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !s) r = 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'h3F80_0000 &&  s) r = 32'h4000_0000;
    if (a == 32'h7F7F_FFFF && b == 32'h7F7F_FFFF && !s) r = 32'h7FFF_FFFF;
    if (a == 32'hFF7F_FFFF && b == 32'hFF7F_FFFF && !s) r = 32'hFF80_0001;
    return r;
  endfunction

  always_ff @(posedge clk) core_o <= core_model(core_a, core_b, core_as);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                       output logic [31:0] res, output logic [3:0] fl, output int lat);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    fl  = out_flags;
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int          l;

    vecs[0]  = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000, 3};
    vecs[1]  = '{32'h40A0_0000, 32'h40A0_0000, 1'b1, 32'h0000_0000, 4'b0011, 1};
    vecs[2]  = '{32'h0000_0000, 32'h4000_0000, 1'b1, 32'hC000_0000, 4'b0001, 1};
    vecs[3]  = '{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 4'b1001, 1};
    vecs[4]  = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 4'b1001, 1};
    vecs[5]  = '{32'h7F80_0000, 32'h3F80_0000, 1'b1, 32'h7F80_0000, 4'b0101, 1};
    vecs[6]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b0100, 3};
    vecs[7]  = '{32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 4'b0000, 3};
    vecs[8]  = '{32'h3F80_0000, 32'h7F80_0000, 1'b1, 32'hFF80_0000, 4'b0101, 1};
    vecs[9]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 4'b0011, 1};
    vecs[10] = '{32'h4000_0000, 32'h0000_0000, 1'b1, 32'h4000_0000, 4'b0001, 1};
    vecs[11] = '{32'hC000_0000, 32'h4000_0000, 1'b0, 32'h0000_0000, 4'b0011, 1};
    vecs[12] = '{32'hFF7F_FFFF, 32'hFF7F_FFFF, 1'b0, 32'hFF80_0000, 4'b0100, 3};
    vecs[13] = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 4'b0001, 1};
    vecs[14] = '{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 4'b1001, 1};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst in_ready",   32'(in_ready),   32'd1);
    check("rst out_valid",  32'(out_valid),  32'd0);
    check("rst out_result", out_result,      32'h0);
    check("rst out_flags",  32'(out_flags),  32'h0);
    check("rst core_a",     core_a,          32'h0);
    check("rst core_as",    32'(core_as),    32'd0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, r, f, l);
      check($sformatf("vec%0d result", i),  r,       vecs[i].res);
      check($sformatf("vec%0d flags", i),   32'(f),  32'(vecs[i].fl));
      check($sformatf("vec%0d latency", i), 32'(l),  32'(vecs[i].lat));
    end

    // Backpressure: result held, new request stalled until the out_ready handshake
    @(negedge clk);
    in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_a = 32'h40A0_0000; in_b = 32'h40A0_0000; in_op = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp out_result", out_result, 32'h4040_0000);
      check("bp in_ready", 32'(in_ready), 32'd0);
      check("bp core_a held", core_a, 32'h3F80_0000);
      @(posedge clk); #1;
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release out_valid", 32'(out_valid), 32'd0);
    check("bp release in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) out_ready = 1'b0;
    @(posedge clk); #1;
    check("bp 2nd out_valid", 32'(out_valid), 32'd1);
    check("bp 2nd result", out_result, 32'h0);
    check("bp 2nd flags", 32'(out_flags), 32'h3);
    @(negedge clk) begin in_valid = 1'b0; out_ready = 1'b1; end
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset while the core operation is in EXEC
    @(negedge clk);
    in_a = 32'h3F80_0000; in_b = 32'h4000_0000; in_op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    l = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) l++;
    end
    check("post-rst no result", 32'(l), 32'd0);
    do_op(32'h3F80_0000, 32'h4000_0000, 1'b0, r, f, l);
    check("post-rst result", r, 32'h4040_0000);
    check("post-rst flags", 32'(f), 32'h0);
    check("post-rst latency", 32'(l), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
